// File: rtl/dpll_trail_pkg.sv
// Shared types for the DPLL assignment trail: trail entry layout, controller states
// and the signed-literal decode used by both the trail and the clause-side blocks.
package dpll_trail_pkg;

    localparam int LIT_W = 9;
    localparam int VAR_W = 8;
    localparam int LVL_W = 8;

    typedef struct packed {
        logic [VAR_W-1:0] var_idx;
        logic [LVL_W-1:0] level;
    } trail_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_DONE
    } trail_state_e;

    // Literals arrive sign-extended to 32 bits so callers of any width can share these.
    function automatic logic [31:0] lit_to_var(input logic [31:0] lit);
        return lit[31] ? (~lit + 32'd1) : lit;
    endfunction

    function automatic logic lit_to_value(input logic [31:0] lit);
        return ~lit[31];
    endfunction

endpackage

// File: rtl/trail_lifo.sv
// Register-array LIFO holding trail entries; the top entry is read combinationally.
module trail_lifo #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        top_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [AW-1:0]     top_idx;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign top_idx = count_q[AW-1:0] - AW'(1);
    assign top_data = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries above count are never read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[count_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/assignment_trail_ctrl.sv
// Assignment trail controller: records assigned literals with their decision level and
// unwinds them on backtrack, pulsing the clause-memory re-update once the vectors settle.
module assignment_trail_ctrl
    import dpll_trail_pkg::*;
#(
    parameter int WIDTH        = LIT_W,
    parameter int MAX_LITERALS = 256,
    parameter int MAX_DEPTH    = 256,
    parameter int LEVEL_W      = LVL_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [WIDTH-1:0]             push_lit,
    input  logic                         push_is_decision,
    input  logic                         bt_valid,
    output logic                         bt_ready,
    input  logic [LEVEL_W-1:0]           bt_level,
    output logic [MAX_LITERALS-1:0]      literal_assigned,
    output logic [MAX_LITERALS-1:0]      literal_bool,
    output logic                         update_from_re_update_module,
    output logic [LEVEL_W-1:0]           current_level,
    output logic [$clog2(MAX_DEPTH):0]   trail_count,
    output logic                         busy,
    output logic                         err_push
);

    localparam int CNT_W = $clog2(MAX_DEPTH) + 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    trail_state_e state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] bt_target_q, bt_target_d;
    logic [MAX_LITERALS-1:0] assigned_q, assigned_d;
    logic [MAX_LITERALS-1:0] bool_q, bool_d;
    logic err_q, err_d;

    logic [31:0]      lit_ext;
    logic [31:0]      push_var;
    logic [VAR_W-1:0] push_idx;
    logic             push_val;
    logic             push_err;
    logic             push_fire;
    logic             bt_fire;
    logic             lifo_push;
    logic             lifo_pop;
    trail_entry_t     push_entry;
    trail_entry_t     top_entry;
    logic [$bits(trail_entry_t)-1:0] top_raw;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    assign lit_ext  = {{(32-WIDTH){push_lit[WIDTH-1]}}, push_lit};
    assign push_var = lit_to_var(lit_ext);
    assign push_val = lit_to_value(lit_ext);
    assign push_idx = push_var[VAR_W-1:0];

    assign push_err = (push_var == 32'd0)
                   || (push_var >= MAX_LITERALS)
                   || assigned_q[push_idx]
                   || (push_is_decision && (level_q == LEVEL_MAX));

    assign push_entry.var_idx = push_idx;
    assign push_entry.level   = push_is_decision ? (level_q + LEVEL_W'(1)) : level_q;
    assign top_entry          = trail_entry_t'(top_raw);

    // A pending backtrack blocks pushes so the trail never grows under a pop.
    assign bt_ready   = (state_q == ST_IDLE);
    assign push_ready = (state_q == ST_IDLE) && !bt_valid && !full;
    assign push_fire  = push_valid && push_ready;
    assign bt_fire    = bt_valid && bt_ready;

    trail_lifo #(
        .DEPTH  (MAX_DEPTH),
        .DATA_W ($bits(trail_entry_t))
    ) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lifo_push),
        .push_data (push_entry),
        .pop       (lifo_pop),
        .top_data  (top_raw),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        bt_target_d = bt_target_q;
        assigned_d  = assigned_q;
        bool_d      = bool_q;
        err_d       = 1'b0;
        lifo_push   = 1'b0;
        lifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bt_fire) begin
                    bt_target_d = bt_level;
                    state_d     = ST_POP;
                end else if (push_fire) begin
                    if (push_err) begin
                        err_d = 1'b1;
                    end else begin
                        lifo_push            = 1'b1;
                        level_d              = push_entry.level;
                        assigned_d[push_idx] = 1'b1;
                        bool_d[push_idx]     = push_val;
                    end
                end
            end
            // One entry unwound per cycle until the top sits at or below the target.
            ST_POP: begin
                if (!empty && (top_entry.level > bt_target_q)) begin
                    lifo_pop                      = 1'b1;
                    assigned_d[top_entry.var_idx] = 1'b0;
                    bool_d[top_entry.var_idx]     = 1'b0;
                end else begin
                    level_d = bt_target_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            bt_target_q <= '0;
            assigned_q  <= '0;
            bool_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            bt_target_q <= bt_target_d;
            assigned_q  <= assigned_d;
            bool_q      <= bool_d;
            err_q       <= err_d;
        end
    end

    assign literal_assigned             = assigned_q;
    assign literal_bool                 = bool_q;
    assign current_level                = level_q;
    assign trail_count                  = count;
    assign busy                         = (state_q != ST_IDLE);
    assign err_push                     = err_q;
    assign update_from_re_update_module = (state_q == ST_DONE);

endmodule

// File: tb/tb_assignment_trail_ctrl.sv
// Scoreboard bench for assignment_trail_ctrl: a trail model predicts every err_push and
// update pulse (cycle and resulting state); a monitor pops and checks them as they appear.
module tb_assignment_trail_ctrl;

    localparam int WIDTH = 9;
    localparam int NLIT  = 256;
    localparam int DEPTH = 4;
    localparam int LW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EV_ERR = 1;
    localparam int EV_UPD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_valid;
    logic              push_ready;
    logic [WIDTH-1:0]  push_lit;
    logic              push_is_decision;
    logic              bt_valid;
    logic              bt_ready;
    logic [LW-1:0]     bt_level;
    logic [NLIT-1:0]   literal_assigned;
    logic [NLIT-1:0]   literal_bool;
    logic              update_from_re_update_module;
    logic [LW-1:0]     current_level;
    logic [CW-1:0]     trail_count;
    logic              busy;
    logic              err_push;

    typedef struct {
        int              kind;
        int              cyc;
        int              lvl;
        int              cnt;
        logic [NLIT-1:0] asg;
        logic [NLIT-1:0] bval;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    logic [NLIT-1:0] m_asg;
    logic [NLIT-1:0] m_bool;
    int              m_level;
    int              tr_var[$];
    int              tr_lvl[$];

    assignment_trail_ctrl #(
        .WIDTH        (WIDTH),
        .MAX_LITERALS (NLIT),
        .MAX_DEPTH    (DEPTH),
        .LEVEL_W      (LW)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .push_valid                   (push_valid),
        .push_ready                   (push_ready),
        .push_lit                     (push_lit),
        .push_is_decision             (push_is_decision),
        .bt_valid                     (bt_valid),
        .bt_ready                     (bt_ready),
        .bt_level                     (bt_level),
        .literal_assigned             (literal_assigned),
        .literal_bool                 (literal_bool),
        .update_from_re_update_module (update_from_re_update_module),
        .current_level                (current_level),
        .trail_count                  (trail_count),
        .busy                         (busy),
        .err_push                     (err_push)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [NLIT-1:0] obs, input logic [NLIT-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_level"}, current_level, m_level);
        checkOutput({tag, "_count"}, trail_count, tr_var.size());
        checkOutput({tag, "_assigned"}, literal_assigned, m_asg);
        checkOutput({tag, "_bool"}, literal_bool, m_bool);
    endtask

    task automatic modelReset();
        m_asg   = '0;
        m_bool  = '0;
        m_level = 0;
        tr_var.delete();
        tr_lvl.delete();
    endtask

    task automatic applyPush(input int lit, input bit dec, output int acc);
        int n;
        int v;
        bit bad;
        push_lit         = lit[WIDTH-1:0];
        push_is_decision = dec;
        push_valid       = 1'b1;
        #1;
        n = 0;
        while (!push_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!push_ready) begin
            checkOutput("push_ready_timeout", push_ready, 1);
            push_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        v = (lit < 0) ? -lit : lit;
        bad = 1'b0;
        if (v == 0 || v >= NLIT) bad = 1'b1;
        else if (m_asg[v]) bad = 1'b1;
        if (dec && m_level == (1 << LW) - 1) bad = 1'b1;
        if (bad) begin
            sb.push_back('{EV_ERR, acc, 0, 0, '0, '0});
        end else begin
            if (dec) m_level++;
            tr_var.push_back(v);
            tr_lvl.push_back(m_level);
            m_asg[v]  = 1'b1;
            m_bool[v] = (lit > 0);
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic applyBacktrack(input int lvl, output int acc, output int k);
        int n;
        int v;
        bt_level = lvl[LW-1:0];
        bt_valid = 1'b1;
        #1;
        n = 0;
        while (!bt_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bt_ready) begin
            checkOutput("bt_ready_timeout", bt_ready, 1);
            bt_valid = 1'b0;
            acc = -1;
            k = 0;
            return;
        end
        acc = cyc + 1;
        k = 0;
        while (tr_lvl.size() > 0 && tr_lvl[tr_lvl.size()-1] > lvl) begin
            v = tr_var.pop_back();
            void'(tr_lvl.pop_back());
            m_asg[v]  = 1'b0;
            m_bool[v] = 1'b0;
            k++;
        end
        m_level = lvl;
        sb.push_back('{EV_UPD, acc + k + 1, m_level, tr_var.size(), m_asg, m_bool});
        @(posedge clk);
        #1;
        bt_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_wait_busy", busy, 0);
    endtask

    // Every pulse must match the oldest prediction; a prediction whose cycle passes unseen is a miss.
    always @(negedge clk) begin
        if (!rst) begin
            if (update_from_re_update_module || err_push) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", {update_from_re_update_module, err_push}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("pulse_kind", update_from_re_update_module ? EV_UPD : EV_ERR, mon_e.kind);
                    checkOutput("pulse_cycle", cyc, mon_e.cyc);
                    if (mon_e.kind == EV_UPD) begin
                        checkOutput("pulse_level", current_level, mon_e.lvl);
                        checkOutput("pulse_count", trail_count, mon_e.cnt);
                        checkOutput("pulse_assigned", literal_assigned, mon_e.asg);
                        checkOutput("pulse_bool", literal_bool, mon_e.bval);
                    end
                end
            end
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checkOutput("missed_pulse_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int acc_bt;
        int k;

        rst              = 1'b1;
        push_valid       = 1'b0;
        push_lit         = '0;
        push_is_decision = 1'b0;
        bt_valid         = 1'b0;
        bt_level         = '0;
        modelReset();

        repeat (3) @(negedge clk);
        checkState("reset_hold");
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_update", update_from_re_update_module, 0);
        checkOutput("reset_err", err_push, 0);
        rst = 1'b0;
        @(negedge clk);
        checkState("reset");

        $display("[TB] test 1: decision and implied push");
        applyPush(5, 1'b1, acc);
        applyPush(-7, 1'b0, acc);
        waitIdle();
        checkState("t1");
        checkOutput("t1_asg5", literal_assigned[5], 1);
        checkOutput("t1_bool5", literal_bool[5], 1);
        checkOutput("t1_asg7", literal_assigned[7], 1);
        checkOutput("t1_bool7", literal_bool[7], 0);

        $display("[TB] test 2: backtrack to level 1");
        applyPush(3, 1'b1, acc);
        applyPush(-9, 1'b0, acc);
        waitIdle();
        checkOutput("t2_full_push_ready", push_ready, 0);
        checkState("t2_pre");
        applyBacktrack(1, acc, k);
        checkOutput("t2_c1_asg9", literal_assigned[9], 1);
        checkOutput("t2_c1_asg3", literal_assigned[3], 1);
        @(posedge clk);
        #1;
        checkOutput("t2_c2_asg9", literal_assigned[9], 0);
        checkOutput("t2_c2_asg3", literal_assigned[3], 1);
        checkOutput("t2_c2_count", trail_count, 3);
        @(posedge clk);
        #1;
        checkOutput("t2_c3_asg3", literal_assigned[3], 0);
        checkOutput("t2_c3_count", trail_count, 2);
        waitIdle();
        checkState("t2");
        checkOutput("t2_asg5", literal_assigned[5], 1);

        $display("[TB] test 3: backtrack beats simultaneous push");
        bt_level         = '0;
        bt_valid         = 1'b1;
        push_lit         = 9'd11;
        push_is_decision = 1'b1;
        push_valid       = 1'b1;
        #1;
        checkOutput("t3_push_ready", push_ready, 0);
        checkOutput("t3_bt_ready", bt_ready, 1);
        applyBacktrack(0, acc_bt, k);
        applyPush(11, 1'b1, acc);
        checkOutput("t3_push_accept_cycle", acc, acc_bt + k + 3);
        waitIdle();
        checkState("t3");

        $display("[TB] test 4: rejected pushes");
        applyPush(11, 1'b1, acc);
        applyPush(-11, 1'b0, acc);
        applyPush(0, 1'b0, acc);
        applyPush(-256, 1'b0, acc);
        waitIdle();
        waitIdle();
        checkState("t4");

        $display("[TB] test 5: full trail then backtrack to level 0");
        applyPush(20, 1'b1, acc);
        applyPush(-21, 1'b0, acc);
        applyPush(22, 1'b1, acc);
        waitIdle();
        checkOutput("t5_full_push_ready", push_ready, 0);
        checkOutput("t5_count", trail_count, 4);
        applyBacktrack(0, acc, k);
        waitIdle();
        checkState("t5");

        $display("[TB] test 5b: level-0 literal survives, empty-pop backtrack");
        applyPush(-30, 1'b0, acc);
        applyPush(31, 1'b1, acc);
        waitIdle();
        applyBacktrack(0, acc, k);
        waitIdle();
        checkState("lvl0");
        checkOutput("lvl0_asg30", literal_assigned[30], 1);
        applyBacktrack(0, acc, k);
        waitIdle();
        checkState("nopop");

        $display("[TB] test 6: reset in the middle of a backtrack");
        applyPush(40, 1'b1, acc);
        applyPush(41, 1'b1, acc);
        waitIdle();
        applyBacktrack(0, acc, k);
        @(posedge clk);
        #2;
        checkOutput("t6_one_pop_count", trail_count, 2);
        checkOutput("t6_one_pop_busy", busy, 1);
        rst = 1'b1;
        #1;
        sb.delete();
        modelReset();
        checkState("t6_rst");
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_update", update_from_re_update_module, 0);
        checkOutput("t6_rst_err", err_push, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyPush(5, 1'b1, acc);
        repeat (6) @(negedge clk);
        checkState("t6_after");

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
